// File: rtl/inst_mem_sync_if.sv
// Fetch and bootload signal bundle for inst_mem_sync; master drives requests, slave is the memory.
interface inst_mem_sync_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    logic              rd_en;
    logic [31:0]       addr;
    logic              stall;
    logic [DATA_W-1:0] data;
    logic              rd_valid;
    logic              addr_fault;
    logic              load_start;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              busy;
    logic [ADDR_W-1:0] load_count;

    modport master (
        output rd_en, addr, stall, load_start, load_valid, load_data, load_last,
        input  data, rd_valid, addr_fault, busy, load_count
    );

    modport slave (
        input  rd_en, addr, stall, load_start, load_valid, load_data, load_last,
        output data, rd_valid, addr_fault, busy, load_count
    );
endinterface

// File: rtl/inst_mem_sync.sv
// Synchronous instruction memory: registered fetch with stall hold and address fault flag.
// Define INST_MEM_BOOTLOAD_EN to add the RUN/LOAD FSM that writes a program image at run time.
module inst_mem_sync #(
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 256,
    parameter string             INIT_FILE = "",
    parameter logic [DATA_W-1:0] NOP_WORD  = '0
) (
    input  logic           clk,
    input  logic           reset,
    inst_mem_sync_if.slave bus,
    output logic           fsm_state
);
    localparam int ADDR_W = $clog2(DEPTH);

    typedef logic [DATA_W-1:0] mem_t [DEPTH];

    function automatic mem_t init_image();
        mem_t img;
        for (int i = 0; i < DEPTH; i++) img[i] = NOP_WORD;
        return img;
    endfunction

    // Contents survive reset.
    mem_t mem = init_image();

    logic [ADDR_W-1:0] idx;
    logic              fault;
    logic              busy;
    logic [DATA_W-1:0] data_q;
    logic              rd_valid_q;
    logic              addr_fault_q;

    assign idx   = bus.addr[ADDR_W+1:2];
    assign fault = (bus.addr[1:0] != 2'b00) ||
                   (bus.addr[31:ADDR_W+2] != '0) ||
                   (32'(idx) >= 32'(DEPTH));

    // Stall freezes all read outputs; a request presented under stall is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q       <= NOP_WORD;
            rd_valid_q   <= 1'b0;
            addr_fault_q <= 1'b0;
        end else if (!bus.stall) begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) begin
                if (busy) begin
                    data_q       <= NOP_WORD;
                    addr_fault_q <= 1'b0;
                end else begin
                    data_q       <= fault ? NOP_WORD : mem[idx];
                    addr_fault_q <= fault;
                end
            end
        end
    end

    assign bus.data       = data_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.addr_fault = addr_fault_q;

`ifdef INST_MEM_BOOTLOAD_EN
    typedef enum logic {RUN = 1'b0, LOAD = 1'b1} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] count, count_n;
    logic              we;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            count <= '0;
        end else begin
            state <= state_n;
            count <= count_n;
        end
    end

    // A restart inside LOAD rewinds the index and suppresses that cycle's write.
    always_comb begin
        state_n = state;
        count_n = count;
        we      = 1'b0;
        case (state)
            RUN: begin
                if (bus.load_start) begin
                    state_n = LOAD;
                    count_n = '0;
                end
            end
            LOAD: begin
                if (bus.load_start) begin
                    count_n = '0;
                end else if (bus.load_valid) begin
                    we      = 1'b1;
                    count_n = count + ADDR_W'(1);
                    if (bus.load_last || count == ADDR_W'(DEPTH - 1)) state_n = RUN;
                end
            end
            default: state_n = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (we && !reset) mem[count] <= bus.load_data;
    end

    assign busy           = (state == LOAD);
    assign fsm_state      = state;
    assign bus.busy       = busy;
    assign bus.load_count = count;
`else
    logic unused_load;

    assign unused_load    = ^{bus.load_start, bus.load_valid, bus.load_data, bus.load_last};
    assign busy           = 1'b0;
    assign fsm_state      = 1'b0;
    assign bus.busy       = 1'b0;
    assign bus.load_count = '0;
`endif
endmodule

// File: tb/tb_inst_mem_sync.sv
// Directed and random fetch/bootload sequences checked against a word-level memory model.
module tb_inst_mem_sync;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic clk;
  logic reset;
  logic fsm_state;

  inst_mem_sync_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  inst_mem_sync #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .INIT_FILE(""), .NOP_WORD(NOP)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .fsm_state(fsm_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model: whole-word memory image plus the visible output state
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] m_data;
  logic        m_valid, m_fault, m_busy;
  logic [7:0]  m_count;
  int n_cmp, n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one clock: drive inputs, predict next outputs, then compare after the edge
  task automatic cyc(input logic r, input logic en, input logic [31:0] a, input logic st,
                     input logic ls, input logic lv, input logic [31:0] ld, input logic ll);
    logic [31:0] nd;
    logic        nv, nf, nb;
    logic [7:0]  nc;
    reset          = r;
    bus.rd_en      = en;
    bus.addr       = a;
    bus.stall      = st;
    bus.load_start = ls;
    bus.load_valid = lv;
    bus.load_data  = ld;
    bus.load_last  = ll;
    nd = m_data; nv = m_valid; nf = m_fault; nb = m_busy; nc = m_count;
    if (r) begin
      nd = NOP; nv = 1'b0; nf = 1'b0; nb = 1'b0; nc = 8'd0;
    end else begin
      if (!st) begin
        nv = en;
        if (en && m_busy) begin
          nd = NOP; nf = 1'b0;
        end else if (en) begin
          nf = (a % 4 != 0) || ((a / 4) >= DEPTH);
          if (nf) nd = NOP;
          else    nd = ref_mem[a / 4];
        end
      end
`ifdef INST_MEM_BOOTLOAD_EN
      if (!m_busy) begin
        if (ls) begin nb = 1'b1; nc = 8'd0; end
      end else if (ls) begin
        nc = 8'd0;
      end else if (lv) begin
        ref_mem[m_count] = ld;
        nc = 8'(m_count + 1);
        if (ll || m_count == DEPTH - 1) nb = 1'b0;
      end
`endif
    end
    @(posedge clk);
    #1;
    m_data = nd; m_valid = nv; m_fault = nf; m_busy = nb; m_count = nc;
    chk("data",       bus.data,       m_data);
    chk("rd_valid",   bus.rd_valid,   m_valid);
    chk("addr_fault", bus.addr_fault, m_fault);
    chk("busy",       bus.busy,       m_busy);
    chk("load_count", bus.load_count, m_count);
    chk("fsm_state",  fsm_state,      m_busy);
  endtask

  task automatic rd(input logic [31:0] a);
    cyc(1'b0, 1'b1, a, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic ld_word(input logic [31:0] d, input logic last, input logic en, input logic [31:0] a);
    cyc(1'b0, en, a, 1'b0, 1'b0, 1'b1, d, last);
  endtask

  initial begin
    logic [31:0] ra;
    n_cmp = 0; n_err = 0;
    reset = 1'b1;
    bus.rd_en = 1'b0; bus.addr = '0; bus.stall = 1'b0;
    bus.load_start = 1'b0; bus.load_valid = 1'b0; bus.load_data = '0; bus.load_last = 1'b0;
    m_data = NOP; m_valid = 1'b0; m_fault = 1'b0; m_busy = 1'b0; m_count = 8'd0;
    #1;
    // stand-in for the INIT_FILE image
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = $urandom | 32'h1;
    ref_mem[0] = 32'h0800_0010;
    ref_mem[1] = 32'h2004_0003;
    ref_mem[2] = 32'h2005_0007;
    ref_mem[3] = 32'h0C00_0003;
    for (int i = 0; i < DEPTH; i++) dut.mem[i] = ref_mem[i];

    // reset state
    cyc(1'b1, 1'b1, 32'h0C, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    // basic fetch
    rd(32'h0C);
    chk("t1_word3", bus.data, 32'h0C00_0003);

    // fault boundaries
    rd(32'h400);
    chk("t2_range_fault", bus.addr_fault, 1'b1);
    rd(32'h06);
    chk("t2_align_fault", bus.addr_fault, 1'b1);
    rd(32'h3FC);
    chk("t2_last_word_ok", bus.addr_fault, 1'b0);
    rd(32'hFFFF_FFFC);
    rd(32'h0000_0401);

    // stall hold: request under stall is dropped, lands one cycle after stall falls
    rd(32'h04);
    cyc(1'b0, 1'b1, 32'h08, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("t3_hold1", bus.data, 32'h2004_0003);
    cyc(1'b0, 1'b1, 32'h08, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("t3_hold2", bus.data, 32'h2004_0003);
    rd(32'h08);
    chk("t3_after", bus.data, 32'h2005_0007);

    // back-to-back, then idle (data holds, rd_valid drops)
    rd(32'h00); rd(32'h04); rd(32'h08);
    cyc(1'b0, 1'b0, 32'h0C, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    // reset in the middle of a load
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    ld_word(32'h1111_0000, 1'b0, 1'b1, 32'h00);
    ld_word(32'h2222_0001, 1'b0, 1'b0, 32'h00);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    rd(32'h00); rd(32'h04); rd(32'h08);

    // full three-word bootload with reads and gaps during the load
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    ld_word(32'hAAAA_0000, 1'b0, 1'b1, 32'h0C);
    cyc(1'b0, 1'b1, 32'h04, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    ld_word(32'hBBBB_0001, 1'b0, 1'b1, 32'h08);
    ld_word(32'hCCCC_0002, 1'b1, 1'b0, 32'h00);
    rd(32'h08);
    rd(32'h00);

    // restart inside a load rewinds to word 0
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    ld_word(32'h5555_0000, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h6666_0000, 1'b0);
    ld_word(32'h7777_0000, 1'b1, 1'b0, 32'h0);
    rd(32'h00); rd(32'h04);

    // load_valid outside a load must not write
    ld_word(32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
    rd(32'h00);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0:       ra = $urandom;
        1:       ra = 32'($urandom_range(0, 1023));
        2:       ra = 32'h400 + (32'($urandom_range(0, 3)) << 2);
        default: ra = 32'($urandom_range(0, DEPTH - 1)) << 2;
      endcase
      cyc(($urandom_range(0, 99) == 0), $urandom_range(0, 1), ra, ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 29) == 0), $urandom_range(0, 1), $urandom, ($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
